// File: rtl/enhance_auto_ctrl.sv
// Auto/manual sequencer for the HSV enhance stage: mode-mapped inc/dec controls,
// per-frame mean S/V via one shared restoring divider, and a dead-band auto loop.
module enhance_auto_ctrl #(
  parameter int         CNT_W    = 19,
  parameter logic [7:0] TARGET_S = 8'd128,
  parameter logic [7:0] TARGET_V = 8'd128,
  parameter logic [7:0] TOL      = 8'd8,
  parameter int         MIN_PIX  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [1:0]  mode,
  input  logic        btn_inc_s,
  input  logic        btn_dec_s,
  input  logic        btn_inc_v,
  input  logic        btn_dec_v,
  input  logic        clear_req,
  input  logic        pix_valid,
  input  logic [23:0] hsv_pix,
  output logic        enhance_en,
  output logic        enhance_user_in_en,
  output logic        inc_saturation,
  output logic        dec_saturation,
  output logic        inc_brightness,
  output logic        dec_brightness,
  output logic [7:0]  mean_s,
  output logic [7:0]  mean_v,
  output logic        stats_valid
);

  localparam int SUM_W = CNT_W + 8;
  localparam int BIT_W = $clog2(SUM_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIX);

  function automatic logic [8:0] lo_thr(input logic [7:0] t, input logic [7:0] tol);
    if (tol > t) lo_thr = 9'd0;
    else         lo_thr = {1'b0, t} - {1'b0, tol};
  endfunction

  function automatic logic [8:0] hi_thr(input logic [7:0] t, input logic [7:0] tol);
    logic [8:0] sum;
    sum = {1'b0, t} + {1'b0, tol};
    if (sum > 9'd255) hi_thr = 9'd255;
    else              hi_thr = sum;
  endfunction

  function automatic logic [7:0] sat8(input logic [SUM_W-1:0] q);
    if (|q[SUM_W-1:8]) sat8 = 8'd255;
    else               sat8 = q[7:0];
  endfunction

  localparam logic [8:0] S_LO = lo_thr(TARGET_S, TOL);
  localparam logic [8:0] S_HI = hi_thr(TARGET_S, TOL);
  localparam logic [8:0] V_LO = lo_thr(TARGET_V, TOL);
  localparam logic [8:0] V_HI = hi_thr(TARGET_V, TOL);

  typedef enum logic [1:0] {ST_ACCUM, ST_DIV_S, ST_DIV_V, ST_DECIDE} state_t;

  state_t             state_r, state_s;
  logic               vsync_r;
  logic               vsync_fall_s;
  logic               low_frame_s;
  logic [SUM_W-1:0]   sum_s_r, sum_v_r, shd_sum_s_r, shd_sum_v_r;
  logic [CNT_W-1:0]   cnt_r, shd_cnt_r;
  logic [CNT_W-1:0]   rem_r, rem_next_s;
  logic [SUM_W-1:0]   quo_r, quo_next_s, div_src_s;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [CNT_W:0]     trial_s;
  logic               q_bit_s, div_busy_s, div_last_s, decide_s, clear_dec_s;
  logic [7:0]         res_s_r, res_v_r;
  logic               auto_inc_s_r, auto_dec_s_r, auto_inc_v_r, auto_dec_v_r;
  logic               unused_hue_s;

  assign unused_hue_s = ^hsv_pix[23:16];
  assign vsync_fall_s = vsync_r & ~vsync;
  assign low_frame_s  = vsync_fall_s && (state_r == ST_ACCUM) && (cnt_r < MIN_CNT);
  assign decide_s     = (state_r == ST_DECIDE);
  assign clear_dec_s  = clear_req || (mode != 2'b10) || low_frame_s;

  // vsync edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_r <= 1'b0;
    else        vsync_r <= vsync;
  end

  // Frame accumulators and their frame-end shadow copies; a pixel in the fall cycle opens the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_s_r     <= '0;
      sum_v_r     <= '0;
      cnt_r       <= '0;
      shd_sum_s_r <= '0;
      shd_sum_v_r <= '0;
      shd_cnt_r   <= '0;
    end else if (vsync_fall_s) begin
      shd_sum_s_r <= sum_s_r;
      shd_sum_v_r <= sum_v_r;
      shd_cnt_r   <= cnt_r;
      if (pix_valid) begin
        sum_s_r <= {{CNT_W{1'b0}}, hsv_pix[15:8]};
        sum_v_r <= {{CNT_W{1'b0}}, hsv_pix[7:0]};
        cnt_r   <= CNT_ONE;
      end else begin
        sum_s_r <= '0;
        sum_v_r <= '0;
        cnt_r   <= '0;
      end
    end else if (pix_valid && !(&cnt_r)) begin
      sum_s_r <= sum_s_r + {{CNT_W{1'b0}}, hsv_pix[15:8]};
      sum_v_r <= sum_v_r + {{CNT_W{1'b0}}, hsv_pix[7:0]};
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // One restoring-divider step: the dividend is read MSB-first straight from the shadow
  always_comb begin
    div_src_s  = shd_sum_s_r;
    rem_next_s = rem_r;
    q_bit_s    = 1'b0;
    if (state_r == ST_DIV_V) div_src_s = shd_sum_v_r;
    else                     div_src_s = shd_sum_s_r;
    trial_s = {rem_r, div_src_s[LAST_BIT - bit_cnt_r]};
    if (trial_s >= {1'b0, shd_cnt_r}) begin
      q_bit_s    = 1'b1;
      rem_next_s = trial_s[CNT_W-1:0] - shd_cnt_r;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = trial_s[CNT_W-1:0];
    end
    quo_next_s = {quo_r[SUM_W-2:0], q_bit_s};
    div_busy_s = (state_r == ST_DIV_S) || (state_r == ST_DIV_V);
    div_last_s = div_busy_s && (bit_cnt_r == LAST_BIT);
  end

  // Divider state and saturated results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r     <= '0;
      quo_r     <= '0;
      bit_cnt_r <= '0;
      res_s_r   <= 8'd0;
      res_v_r   <= 8'd0;
    end else if (vsync_fall_s) begin
      rem_r     <= '0;
      quo_r     <= '0;
      bit_cnt_r <= '0;
    end else if (div_last_s) begin
      rem_r     <= '0;
      quo_r     <= '0;
      bit_cnt_r <= '0;
      if (state_r == ST_DIV_S) res_s_r <= sat8(quo_next_s);
      else                     res_v_r <= sat8(quo_next_s);
    end else if (div_busy_s) begin
      rem_r     <= rem_next_s;
      quo_r     <= quo_next_s;
      bit_cnt_r <= bit_cnt_r + BIT_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_ACCUM;
    else        state_r <= state_s;
  end

  // FSM next state; a frame end outside ACCUM always restarts the division
  always_comb begin
    state_s = state_r;
    if (vsync_fall_s) begin
      if (low_frame_s) state_s = ST_ACCUM;
      else             state_s = ST_DIV_S;
    end else begin
      case (state_r)
        ST_ACCUM:  state_s = ST_ACCUM;
        ST_DIV_S:  state_s = div_last_s ? ST_DIV_V : ST_DIV_S;
        ST_DIV_V:  state_s = div_last_s ? ST_DECIDE : ST_DIV_V;
        ST_DECIDE: state_s = ST_ACCUM;
        default:   state_s = ST_ACCUM;
      endcase
    end
  end

  // Published means and the stats pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_s      <= 8'd0;
      mean_v      <= 8'd0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= decide_s;
      if (decide_s) begin
        mean_s <= res_s_r;
        mean_v <= res_v_r;
      end
    end
  end

  // Auto decisions, dead band compared at 9 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_inc_s_r <= 1'b0;
      auto_dec_s_r <= 1'b0;
      auto_inc_v_r <= 1'b0;
      auto_dec_v_r <= 1'b0;
    end else if (clear_dec_s) begin
      auto_inc_s_r <= 1'b0;
      auto_dec_s_r <= 1'b0;
      auto_inc_v_r <= 1'b0;
      auto_dec_v_r <= 1'b0;
    end else if (decide_s) begin
      auto_inc_s_r <= ({1'b0, res_s_r} < S_LO);
      auto_dec_s_r <= ({1'b0, res_s_r} > S_HI);
      auto_inc_v_r <= ({1'b0, res_v_r} < V_LO);
      auto_dec_v_r <= ({1'b0, res_v_r} > V_HI);
    end
  end

  // Mode-mapped outputs to the enhance stage; clear_req overrides for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enhance_en         <= 1'b0;
      enhance_user_in_en <= 1'b0;
      inc_saturation     <= 1'b0;
      dec_saturation     <= 1'b0;
      inc_brightness     <= 1'b0;
      dec_brightness     <= 1'b0;
    end else if (clear_req) begin
      enhance_en         <= (mode != 2'b00);
      enhance_user_in_en <= 1'b1;
      inc_saturation     <= 1'b1;
      dec_saturation     <= 1'b1;
      inc_brightness     <= 1'b1;
      dec_brightness     <= 1'b1;
    end else begin
      case (mode)
        2'b01: begin
          enhance_en         <= 1'b1;
          enhance_user_in_en <= 1'b1;
          inc_saturation     <= btn_inc_s;
          dec_saturation     <= btn_dec_s;
          inc_brightness     <= btn_inc_v;
          dec_brightness     <= btn_dec_v;
        end
        2'b10: begin
          enhance_en         <= 1'b1;
          enhance_user_in_en <= 1'b1;
          inc_saturation     <= auto_inc_s_r;
          dec_saturation     <= auto_dec_s_r;
          inc_brightness     <= auto_inc_v_r;
          dec_brightness     <= auto_dec_v_r;
        end
        2'b11: begin
          enhance_en         <= 1'b1;
          enhance_user_in_en <= 1'b0;
          inc_saturation     <= 1'b0;
          dec_saturation     <= 1'b0;
          inc_brightness     <= 1'b0;
          dec_brightness     <= 1'b0;
        end
        default: begin
          enhance_en         <= 1'b0;
          enhance_user_in_en <= 1'b0;
          inc_saturation     <= 1'b0;
          dec_saturation     <= 1'b0;
          inc_brightness     <= 1'b0;
          dec_brightness     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/enhance_auto_ctrl.md
Name: enhance_auto_ctrl

Overview:
- Controller that sequences the HSV enhance stage. Drives its enable, user-input-enable and inc/dec saturation/brightness controls.
- Modes: off, manual (button pass-through), auto (closed-loop), freeze.
- In auto, accumulates per-frame mean S and V of the enhanced pixel stream. One shared serial divider computes the means. A frame-rate inc/dec decision steers the means toward target windows.
- Sits between the button/switch logic and the enhance stage; taps the enhance output stream.

Parameters:
- CNT_W, 19, pixel counter width (covers 640x480).
- TARGET_S, 8'd128, auto saturation target.
- TARGET_V, 8'd128, auto brightness target.
- TOL, 8'd8, half-width of dead band around each target.
- MIN_PIX, 1024, minimum valid pixels per frame for a decision.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- vsync  in  1  vertical sync; a falling edge marks frame end
- mode  in  2  00 off, 01 manual, 10 auto, 11 freeze
- btn_inc_s, btn_dec_s, btn_inc_v, btn_dec_v  in  1 each  debounced user buttons (level)
- clear_req  in  1  one-cycle request to zero the enhance offsets
- pix_valid  in  1  hsv_pix is an active-area pixel
- hsv_pix  in  24  enhance output {H,S,V}
- enhance_en  out  1  to enhance stage
- enhance_user_in_en  out  1  to enhance stage
- inc_saturation, dec_saturation, inc_brightness, dec_brightness  out  1 each  to enhance stage
- mean_s, mean_v  out  8  last computed frame means
- stats_valid  out  1  one-cycle pulse when both means update

Behaviour:
- Reset values: all outputs 0; accumulators, shadow registers and auto decisions 0; FSM in ACCUM.
- All outputs are registered.
- Edge detection: vsync_fall is true when the registered vsync is 1 and vsync is 0.
- Accumulation (always running, every mode):
  - On pix_valid: sum_s += S, sum_v += V, cnt += 1.
  - Sums are CNT_W+8 bits; cnt saturates at all-ones, and sums stop adding once cnt saturates.
  - On vsync_fall: copy sums and cnt into shadow registers; accumulators restart. A pixel valid in that same cycle loads as the first pixel of the new frame.
- FSM states: ACCUM, DIV_S, DIV_V, DECIDE.
- ACCUM -> DIV_S on vsync_fall.
  - If shadow cnt < MIN_PIX: go to ACCUM instead. Means are unchanged, no stats_valid pulse, auto decisions cleared to none.
- DIV_S: restoring divider, one quotient bit per cycle, CNT_W+8 cycles, computing floor(sum_s/cnt). The result saturates at 255. Then -> DIV_V.
- DIV_V: same divider, reused, on sum_v. Then -> DECIDE.
- DECIDE (one cycle):
  - Load mean_s and mean_v; pulse stats_valid.
  - Saturation decision: inc if mean_s < TARGET_S-TOL; dec if mean_s > TARGET_S+TOL; otherwise none.
  - Brightness decision: same rule using mean_v and TARGET_V. Comparisons are done at 9-bit width; target±TOL clamps to 0..255.
  - Then -> ACCUM.
- A vsync_fall in any state other than ACCUM aborts the current division, reloads the shadow registers and restarts DIV_S.
- Output mapping, registered one cycle from the inputs:
  - 00: enhance_en=0, user_in_en=0, inc/dec=0.
  - 01: enhance_en=1, user_in_en=1, inc/dec follow the btn_* inputs.
  - 10: enhance_en=1, user_in_en=1, inc/dec follow the auto decisions.
  - 11: enhance_en=1, user_in_en=0, inc/dec=0; offsets are held.
- Decision timing:
  - Decisions change only in DECIDE, which never coincides with vsync_fall.
  - The enhance stage samples them at the next vsync_fall, so the loop latency is one frame.
  - Auto never asserts inc and dec together.
- Leaving mode 10 clears the auto decisions; re-entering mode 10 waits for the next DECIDE.
- clear_req, in any mode:
  - Next cycle: all four inc/dec = 1 and user_in_en = 1 for exactly one cycle; enhance_en keeps its mode value.
  - Auto decisions are cleared.
  - clear_req wins over a simultaneous mode or button input.
- Manual mode with both buttons of a pair pressed passes through unchanged (the enhance stage treats it as no change).
- Reset asserted mid-division: immediate return to reset values.

Test Plan:
- Reset, mode=10, 2000 pixels/frame at S=64, V=200 -> after the first vsync_fall: mean_s=64, mean_v=200, stats_valid pulse; inc_saturation=1 and dec_brightness=1 held through the next vsync_fall.
- Mode=10, 2000 pixels at S=130, V=120 -> mean_s=130, mean_v=120; all inc/dec=0 (inside dead band).
- Frame of 500 pixels (< MIN_PIX) -> no stats_valid; means unchanged; decisions cleared.
- Mode=01, btn_inc_v=1 -> inc_brightness=1 one cycle later, user_in_en=1; mode=11 -> user_in_en=0, enhance_en=1, all inc/dec 0.
- clear_req pulse while in mode=10 with inc_saturation=1 -> one cycle with all four inc/dec=1 and user_in_en=1, then all inc/dec 0 until the next DECIDE.
- vsync_fall injected 10 cycles into DIV_S with new data (S=10) -> division restarts; mean_s=10; only one stats_valid pulse.
